// File: rtl/core_cluster_mem_arbiter_if.sv
// Request/response bundle for N lanes. The arbiter is the slave on the per-core
// side (N=NUM_CORES) and the master on the shared memory side (N=1).
interface core_cluster_mem_arbiter_if #(
    parameter int N          = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [N-1:0]              req_valid;
    logic [N*ADDR_WIDTH-1:0]   req_addr;
    logic [N*DATA_WIDTH-1:0]   req_wdata;
    logic [N*DATA_WIDTH/8-1:0] req_be;
    logic [N-1:0]              req_we;
    logic [N-1:0]              req_ready;
    logic [N-1:0]              rsp_valid;
    logic [DATA_WIDTH-1:0]     rsp_rdata;

    modport master (
        output req_valid, req_addr, req_wdata, req_be, req_we,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_be, req_we,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/core_cluster_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among NUM_CORES cores, with a
// tag FIFO of granted core indices that steers in-order responses back.
module core_cluster_mem_arbiter #(
    parameter int NUM_CORES       = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    core_cluster_mem_arbiter_if.slave    core,
    core_cluster_mem_arbiter_if.master   mem,
    output logic                         busy,
    output logic                         rsp_error
);
    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int BE_W  = DATA_WIDTH / 8;

    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  lock_q, lock_d;
    logic [IDX_W-1:0]      locked_idx_q, locked_idx_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [NUM_CORES-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_error_q, rsp_error_d;
    logic [IDX_W-1:0]      tag_mem [MAX_OUTSTANDING];

    logic [IDX_W-1:0]      grant, cand;
    logic                  found, full, req_valid, fire, push, pop;
    logic [IDX_W-1:0]      head;
    logic [NUM_CORES-1:0]  req_ready;

    // Scan upward from rr_ptr with wrap; a stalled grant stays locked until it fires.
    always_comb begin
        grant = rr_ptr_q;
        cand  = rr_ptr_q;
        found = 1'b0;
        for (int k = 0; k < NUM_CORES; k++) begin
            cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_CORES);
            if (!found && core.req_valid[cand]) begin
                grant = cand;
                found = 1'b1;
            end
        end
        if (lock_q) begin
            grant = locked_idx_q;
        end
    end

    assign full      = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign req_valid = (lock_q | (|core.req_valid)) & ~full;
    assign fire      = req_valid & mem.req_ready;
    assign push      = fire;
    assign pop       = mem.rsp_valid & (count_q != '0);
    assign head      = tag_mem[rd_ptr_q];

    assign mem.req_valid = req_valid;
    assign mem.req_addr  = core.req_addr[grant*ADDR_WIDTH +: ADDR_WIDTH];
    assign mem.req_wdata = core.req_wdata[grant*DATA_WIDTH +: DATA_WIDTH];
    assign mem.req_be    = core.req_be[grant*BE_W +: BE_W];
    assign mem.req_we    = core.req_we[grant];

    always_comb begin
        req_ready = '0;
        if (fire) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign core.req_ready = req_ready;
    assign core.rsp_valid = rsp_valid_q;
    assign core.rsp_rdata = rsp_rdata_q;
    assign busy           = (count_q != '0) | lock_q;
    assign rsp_error      = rsp_error_q;

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        lock_d       = lock_q;
        locked_idx_d = locked_idx_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        rsp_valid_d  = '0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_error_d  = rsp_error_q;

        if (fire) begin
            lock_d   = 1'b0;
            rr_ptr_d = (grant == IDX_W'(NUM_CORES - 1)) ? '0 : grant + 1'b1;
            wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
        end else if (req_valid) begin
            lock_d       = 1'b1;
            locked_idx_d = grant;
        end

        if (pop) begin
            rd_ptr_d          = (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
            rsp_valid_d[head] = 1'b1;
            rsp_rdata_d       = mem.rsp_rdata;
        end else if (mem.rsp_valid) begin
            rsp_error_d = 1'b1;
        end

        // Full blocks push, so a push with no pop never overflows the count.
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            lock_q       <= 1'b0;
            locked_idx_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_error_q  <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            lock_q       <= lock_d;
            locked_idx_q <= locked_idx_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_error_q  <= rsp_error_d;
        end
    end

    // Tag storage is only meaningful between push and pop, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_q] <= grant;
        end
    end
endmodule

// File: tb/tb_core_cluster_mem_arbiter.sv
// Directed bench for core_cluster_mem_arbiter: stimulus pushes expected grants and
// responses into queues; a negedge monitor pops and compares them.
module tb_core_cluster_mem_arbiter;
    typedef struct packed {
        logic [3:0]  oh;
        logic [31:0] val;
    } exp_t;

    logic clk;
    logic rst;
    logic busy;
    logic rsp_error;
    int   n_checks;
    int   n_pass;
    exp_t gq[$];
    exp_t rq[$];

    core_cluster_mem_arbiter_if #(.N(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) core_if ();
    core_cluster_mem_arbiter_if #(.N(1), .ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_if ();

    core_cluster_mem_arbiter #(
        .NUM_CORES(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .core(core_if.slave),
        .mem(mem_if.master),
        .busy(busy),
        .rsp_error(rsp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] oh(input int i);
        logic [3:0] one;
        one = 4'b0001;
        return one << i;
    endfunction

    task automatic set_core(input int i, input logic v, input logic [31:0] a, input logic we);
        core_if.req_valid[i]        = v;
        core_if.req_addr[i*32 +: 32]  = a;
        core_if.req_wdata[i*32 +: 32] = a ^ 32'h0000_FFFF;
        core_if.req_be[i*4 +: 4]      = 4'hF;
        core_if.req_we[i]           = we;
    endtask

    task automatic mem_rsp(input logic v, input logic [31:0] d);
        mem_if.rsp_valid[0] = v;
        mem_if.rsp_rdata    = d;
    endtask

    task automatic idle_cores();
        for (int i = 0; i < 4; i++) set_core(i, 1'b0, 32'h0, 1'b0);
    endtask

    // Monitor: compares every handshake and every response strobe against the queues.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_if.req_valid[0] && mem_if.req_ready[0]) begin
                    if (gq.size() == 0) begin
                        n_checks++;
                        $display("FAIL grant_unexpected actual_ready=%b required=none", core_if.req_ready);
                    end else begin
                        e = gq.pop_front();
                        check("grant_ready", 64'(core_if.req_ready), 64'(e.oh));
                        check("grant_addr", 64'(mem_if.req_addr), 64'(e.val));
                    end
                end
                if (core_if.rsp_valid != 4'b0000) begin
                    if (rq.size() == 0) begin
                        n_checks++;
                        $display("FAIL rsp_unexpected actual_valid=%b required=none", core_if.rsp_valid);
                    end else begin
                        e = rq.pop_front();
                        check("rsp_valid", 64'(core_if.rsp_valid), 64'(e.oh));
                        check("rsp_rdata", 64'(core_if.rsp_rdata), 64'(e.val));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        core_if.req_valid = '0;
        core_if.req_addr  = '0;
        core_if.req_wdata = '0;
        core_if.req_be    = '0;
        core_if.req_we    = '0;
        mem_if.req_ready  = '0;
        mem_if.rsp_valid  = '0;
        mem_if.rsp_rdata  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req_valid", 64'(mem_if.req_valid), 64'd0);
        check("rst_core_req_ready", 64'(core_if.req_ready), 64'd0);
        check("rst_core_rsp_valid", 64'(core_if.rsp_valid), 64'd0);
        check("rst_core_rsp_rdata", 64'(core_if.rsp_rdata), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rsp_error", 64'(rsp_error), 64'd0);
        rst = 1'b0;
        tick();

        // Single read from core 2 with a one-cycle response.
        set_core(2, 1'b1, 32'h100, 1'b0);
        mem_if.req_ready = 1'b1;
        gq.push_back('{4'b0100, 32'h100});
        tick();
        set_core(2, 1'b0, 32'h100, 1'b0);
        mem_rsp(1'b1, 32'hDEAD_BEEF);
        rq.push_back('{4'b0100, 32'hDEAD_BEEF});
        tick();
        mem_rsp(1'b0, 32'h0);
        check("t1_rsp_latency", 64'(core_if.rsp_valid), 64'(4'b0100));
        tick();

        // Fresh reset, then all four cores request continuously.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) gq.push_back('{oh(k % 4), 32'h200 + 32'((k % 4) * 16)});
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < 4; i++) set_core(i, c < 8, 32'h200 + 32'(i * 16), 1'b0);
            if (c >= 2) begin
                mem_rsp(1'b1, 32'hA000 + 32'(c - 2));
                rq.push_back('{oh((c - 2) % 4), 32'hA000 + 32'(c - 2)});
            end
            tick();
        end
        mem_rsp(1'b0, 32'h0);
        tick();

        // Core 1 stalled by the memory; core 0 arrives later and must wait.
        mem_if.req_ready = 1'b0;
        set_core(1, 1'b1, 32'h310, 1'b0);
        tick();
        set_core(0, 1'b1, 32'h300, 1'b0);
        check("t3_lock_addr_a", 64'(mem_if.req_addr), 64'h310);
        tick();
        check("t3_lock_addr_b", 64'(mem_if.req_addr), 64'h310);
        tick();
        mem_if.req_ready = 1'b1;
        gq.push_back('{4'b0010, 32'h310});
        gq.push_back('{4'b0001, 32'h300});
        tick();
        set_core(1, 1'b0, 32'h310, 1'b0);
        tick();
        set_core(0, 1'b0, 32'h300, 1'b0);
        mem_rsp(1'b1, 32'h33);
        rq.push_back('{4'b0010, 32'h33});
        tick();
        mem_rsp(1'b1, 32'h30);
        rq.push_back('{4'b0001, 32'h30});
        tick();
        mem_rsp(1'b0, 32'h0);
        tick();

        // Fill the tag FIFO with no responses; round-robin resumes at core 1.
        for (int i = 0; i < 4; i++) set_core(i, 1'b1, 32'h400 + 32'(i * 16), 1'b0);
        gq.push_back('{4'b0010, 32'h410});
        gq.push_back('{4'b0100, 32'h420});
        gq.push_back('{4'b1000, 32'h430});
        gq.push_back('{4'b0001, 32'h400});
        repeat (4) tick();
        check("t4_full_valid", 64'(mem_if.req_valid), 64'd0);
        check("t4_full_ready", 64'(core_if.req_ready), 64'd0);
        check("t4_full_busy", 64'(busy), 64'd1);
        tick();
        mem_rsp(1'b1, 32'h40);
        rq.push_back('{4'b0010, 32'h40});
        check("t4_pop_no_bypass", 64'(mem_if.req_valid), 64'd0);
        gq.push_back('{4'b0010, 32'h410});
        tick();
        mem_rsp(1'b0, 32'h0);
        check("t4_slot_freed", 64'(mem_if.req_valid), 64'd1);
        tick();
        check("t4_full_again", 64'(mem_if.req_valid), 64'd0);
        idle_cores();
        mem_rsp(1'b1, 32'h41);
        rq.push_back('{4'b0100, 32'h41});
        tick();
        mem_rsp(1'b1, 32'h42);
        rq.push_back('{4'b1000, 32'h42});
        tick();
        mem_rsp(1'b1, 32'h43);
        rq.push_back('{4'b0001, 32'h43});
        tick();
        mem_rsp(1'b1, 32'h44);
        rq.push_back('{4'b0010, 32'h44});
        tick();
        mem_rsp(1'b0, 32'h0);
        tick();

        // Interleaved cores 3, 0 (write), 3 with in-order responses.
        set_core(3, 1'b1, 32'h530, 1'b0);
        gq.push_back('{4'b1000, 32'h530});
        tick();
        set_core(3, 1'b0, 32'h530, 1'b0);
        set_core(0, 1'b1, 32'h500, 1'b1);
        gq.push_back('{4'b0001, 32'h500});
        tick();
        set_core(0, 1'b0, 32'h500, 1'b0);
        set_core(3, 1'b1, 32'h534, 1'b0);
        gq.push_back('{4'b1000, 32'h534});
        mem_rsp(1'b1, 32'hAAAA_0001);
        rq.push_back('{4'b1000, 32'hAAAA_0001});
        tick();
        set_core(3, 1'b0, 32'h534, 1'b0);
        mem_rsp(1'b1, 32'hBBBB_0002);
        rq.push_back('{4'b0001, 32'hBBBB_0002});
        tick();
        mem_rsp(1'b1, 32'hCCCC_0003);
        rq.push_back('{4'b1000, 32'hCCCC_0003});
        tick();
        mem_rsp(1'b0, 32'h0);
        repeat (2) tick();

        // Orphan response sets the sticky error without a core strobe.
        check("t6_err_before", 64'(rsp_error), 64'd0);
        mem_rsp(1'b1, 32'h66);
        tick();
        mem_rsp(1'b0, 32'h0);
        check("t6_err_set", 64'(rsp_error), 64'd1);
        check("t6_no_strobe", 64'(core_if.rsp_valid), 64'd0);
        tick();
        check("t6_err_sticky", 64'(rsp_error), 64'd1);

        // Reset mid-burst: after granting core 2, rr_ptr would point at core 3.
        set_core(2, 1'b1, 32'h620, 1'b0);
        set_core(3, 1'b1, 32'h630, 1'b0);
        gq.push_back('{4'b0100, 32'h620});
        tick();
        rst = 1'b1;
        #1;
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_err", 64'(rsp_error), 64'd0);
        check("t6_rst_rr_ptr", 64'(mem_if.req_addr), 64'h620);
        check("t6_rst_rsp_valid", 64'(core_if.rsp_valid), 64'd0);
        idle_cores();
        tick();
        rst = 1'b0;
        repeat (3) tick();

        check("grant_queue_drained", 64'(gq.size()), 64'd0);
        check("rsp_queue_drained", 64'(rq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
